// File: rtl/dec_ib_pkg.sv
// Shared types and field offsets for the decode instruction-buffer queue.
// An entry carries the 32-bit instruction, its 16-bit compressed form and 70 bits of PC/fault data.
package dec_ib_pkg;

    localparam int IB_PCDATA_W          = 70;

    localparam int IB_FETCH_PAGE_FAULT  = 69;
    localparam int IB_ICAF_F1           = 68;
    localparam int IB_DBECC             = 67;
    localparam int IB_SBECC             = 66;
    localparam int IB_PERR              = 65;
    localparam int IB_ICAF              = 64;
    localparam int IB_PC_HI             = 63;
    localparam int IB_PC_LO             = 1;
    localparam int IB_PC4               = 0;

    typedef struct packed {
        logic [31:0]            instr;
        logic [15:0]            cinst;
        logic [IB_PCDATA_W-1:0] pcdata;
    } ib_entry_t;

    localparam int IB_ENTRY_W = $bits(ib_entry_t);

endpackage

// File: rtl/dec_ib_bypass_queue_lane_mux.sv
// One decode lane: picks the stored entry, else the bypassed write entry, else drives zero.
module dec_ib_lane_mux #(
    parameter int PAYLOAD_W = 118
) (
    input  logic                 st_valid_i,
    input  logic [PAYLOAD_W-1:0] st_data_i,
    input  logic                 byp_valid_i,
    input  logic [PAYLOAD_W-1:0] byp_data_i,
    output logic                 valid_o,
    output logic [PAYLOAD_W-1:0] data_o
);

    always_comb begin
        valid_o = st_valid_i | byp_valid_i;
        data_o  = '0;
        if (st_valid_i) begin
            data_o = st_data_i;
        end else if (byp_valid_i) begin
            data_o = byp_data_i;
        end
    end

endmodule

// File: rtl/dec_ib_bypass_queue.sv
// Multi-lane instruction queue between fetch-align and decode; presents the NUM_LANES oldest entries.
// Define DEC_IB_BYPASS_EN to let same-cycle write data fill lanes beyond the stored count.
module dec_ib_bypass_queue
    import dec_ib_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = IB_ENTRY_W
) (
    input  logic                           clk,
    input  logic                           rst_l,
    input  logic                           flush,
    input  logic [NUM_LANES-1:0]           wr_valid,
    input  logic [NUM_LANES*PAYLOAD_W-1:0] wr_data,
    output logic                           wr_ready,
    output logic [NUM_LANES-1:0]           rd_valid,
    output logic [NUM_LANES*PAYLOAD_W-1:0] rd_data,
    input  logic [$clog2(NUM_LANES+1)-1:0] rd_consume,
    output logic [$clog2(DEPTH+1)-1:0]     ib_count,
    output logic                           ib_overflow,
    output logic                           ib_underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [PAYLOAD_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;

    logic                 wr_acc;
    int                   n_wr;
    int                   n_avail;
    int                   n_rd;
    int                   n_rd_st;
    int                   n_byp;
    int                   n_wr_st;
    int                   n_st_lanes;

    logic [NUM_LANES-1:0]                st_valid;
    logic [NUM_LANES-1:0]                byp_valid;
    logic [NUM_LANES-1:0][PAYLOAD_W-1:0] st_data;
    logic [NUM_LANES-1:0][PAYLOAD_W-1:0] byp_data;

    assign wr_ready     = (DEPTH - int'(count_q)) >= NUM_LANES;
    assign n_wr         = $countones(wr_valid);
    assign wr_acc       = wr_valid[0] & wr_ready & ~flush;
    assign ib_count     = count_q;
    assign ib_overflow  = ovf_q;
    assign ib_underflow = udf_q;

    // Lanes below the count come from storage; the rest may take fresh write lanes in order.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            st_valid[k]  = k < int'(count_q);
            st_data[k]   = mem_q[PW'(int'(rd_ptr_q) + k)];
            byp_valid[k] = 1'b0;
            byp_data[k]  = '0;
`ifdef DEC_IB_BYPASS_EN
            if (wr_acc && (k >= int'(count_q)) && ((k - int'(count_q)) < n_wr)) begin
                byp_valid[k] = 1'b1;
                byp_data[k]  = wr_data[(k - int'(count_q))*PAYLOAD_W +: PAYLOAD_W];
            end
`endif
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dec_ib_lane_mux #(.PAYLOAD_W(PAYLOAD_W)) u_mux (
            .st_valid_i  (st_valid[g]),
            .st_data_i   (st_data[g]),
            .byp_valid_i (byp_valid[g]),
            .byp_data_i  (byp_data[g]),
            .valid_o     (rd_valid[g]),
            .data_o      (rd_data[g*PAYLOAD_W +: PAYLOAD_W])
        );
    end

    // Consumption drains storage first; anything beyond that came straight from the bypass.
    always_comb begin
        n_st_lanes = (int'(count_q) >= NUM_LANES) ? NUM_LANES : int'(count_q);
        n_avail    = n_st_lanes;
`ifdef DEC_IB_BYPASS_EN
        if (wr_acc) begin
            n_avail = n_st_lanes + ((n_wr < (NUM_LANES - n_st_lanes)) ? n_wr : (NUM_LANES - n_st_lanes));
        end
`endif
        n_rd     = (int'(rd_consume) > n_avail) ? n_avail : int'(rd_consume);
        n_rd_st  = (n_rd > int'(count_q)) ? int'(count_q) : n_rd;
        n_byp    = n_rd - n_rd_st;
        n_wr_st  = wr_acc ? (n_wr - n_byp) : 0;

        rd_ptr_d = PW'(int'(rd_ptr_q) + n_rd_st);
        wr_ptr_d = PW'(int'(wr_ptr_q) + n_wr_st);
        count_d  = CW'(int'(count_q) + n_wr_st - n_rd_st);
        ovf_d    = ovf_q | (wr_valid[0] & ~wr_ready);
        udf_d    = udf_q | (int'(rd_consume) > n_avail);

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage needs no reset: unoccupied slots are masked to zero by the lane muxes.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_LANES; k++) begin
            if (wr_acc && (k >= n_byp) && (k < n_wr)) begin
                mem_q[PW'(int'(wr_ptr_q) + k - n_byp)] <= wr_data[k*PAYLOAD_W +: PAYLOAD_W];
            end
        end
    end

    a_wr_valid_contiguous: assert property (@(posedge clk) disable iff (!rst_l)
        ((wr_valid & (wr_valid + NUM_LANES'(1))) == '0));

endmodule

// File: tb/tb_dec_ib_bypass_queue.sv
// Directed bench for dec_ib_bypass_queue at NUM_LANES=2, DEPTH=8.
// Expectations follow DEC_IB_BYPASS_EN when the bench is built with it.
module tb_dec_ib_bypass_queue;

    localparam int PW = 118;

    logic          clk = 1'b0;
    logic          rst_l;
    logic          flush;
    logic [1:0]    wr_valid;
    logic [2*PW-1:0] wr_data;
    logic          wr_ready;
    logic [1:0]    rd_valid;
    logic [2*PW-1:0] rd_data;
    logic [1:0]    rd_consume;
    logic [3:0]    ib_count;
    logic          ib_overflow;
    logic          ib_underflow;

    int checks   = 0;
    int failures = 0;

    dec_ib_bypass_queue dut (
        .clk          (clk),
        .rst_l        (rst_l),
        .flush        (flush),
        .wr_valid     (wr_valid),
        .wr_data      (wr_data),
        .wr_ready     (wr_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_consume   (rd_consume),
        .ib_count     (ib_count),
        .ib_overflow  (ib_overflow),
        .ib_underflow (ib_underflow)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] mk(input int t);
        mk = {32'hC0DE_0000 | 32'(t), 16'(t), 70'(t)};
    endfunction

    task automatic drive(input logic [1:0] v, input int t0, input int t1, input int cons);
        wr_valid   = v;
        wr_data    = {mk(t1), mk(t0)};
        rd_consume = 2'(cons);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        drive(2'b00, 0, 0, 0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        flush = 1'b0;
        drive(2'b00, 0, 0, 0);
        #12;
        checks++; if (ib_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", ib_count); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (rd_valid !== 2'b00) begin failures++; $display("[TB] FAIL reset_rd_valid got=%b exp=00", rd_valid); end
        checks++; if (rd_data !== '0) begin failures++; $display("[TB] FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if ({ib_overflow, ib_underflow} !== 2'b00) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=00", {ib_overflow, ib_underflow}); end
        rst_l = 1'b1;
        cycle();
        // Hold five entries, then reset mid-cycle and look before any clock edge.
        drive(2'b11, 1, 2, 0); cycle();
        drive(2'b11, 3, 4, 0); cycle();
        drive(2'b01, 5, 0, 0); cycle();
        drive(2'b00, 0, 0, 0);
        checks++; if (ib_count !== 4'd5) begin failures++; $display("[TB] FAIL midrst_pre_count got=%0d exp=5", ib_count); end
        #2 rst_l = 1'b0;
        #1;
        checks++; if (ib_count !== 4'd0) begin failures++; $display("[TB] FAIL midrst_count got=%0d exp=0", ib_count); end
        checks++; if (rd_valid !== 2'b00) begin failures++; $display("[TB] FAIL midrst_rd_valid got=%b exp=00", rd_valid); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL midrst_wr_ready got=%b exp=1", wr_ready); end
        @(posedge clk);
        #2 rst_l = 1'b1;
        cycle();
    endtask

    task automatic test_fill_full();
        for (int i = 0; i < 3; i++) begin
            drive(2'b11, 2*i, 2*i+1, 0);
            cycle();
        end
        drive(2'b00, 0, 0, 0);
        checks++; if (ib_count !== 4'd6) begin failures++; $display("[TB] FAIL fill_count6 got=%0d exp=6", ib_count); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL fill_ready6 got=%b exp=1", wr_ready); end
        drive(2'b11, 6, 7, 0); cycle();
        drive(2'b00, 0, 0, 0);
        checks++; if (ib_count !== 4'd8) begin failures++; $display("[TB] FAIL full_count got=%0d exp=8", ib_count); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready got=%b exp=0", wr_ready); end
        checks++; if (ib_overflow !== 1'b0) begin failures++; $display("[TB] FAIL full_ovf_early got=%b exp=0", ib_overflow); end
        drive(2'b11, 8, 9, 0); cycle();
        drive(2'b00, 0, 0, 0);
        checks++; if (ib_count !== 4'd8) begin failures++; $display("[TB] FAIL drop_count got=%0d exp=8", ib_count); end
        checks++; if (ib_overflow !== 1'b1) begin failures++; $display("[TB] FAIL drop_ovf got=%b exp=1", ib_overflow); end
        checks++; if (rd_data !== {mk(1), mk(0)}) begin failures++; $display("[TB] FAIL full_oldest got=%h exp=%h", rd_data, {mk(1), mk(0)}); end
        do_flush();
        checks++; if (ib_overflow !== 1'b0) begin failures++; $display("[TB] FAIL flush_ovf_clear got=%b exp=0", ib_overflow); end
    endtask

    task automatic test_wrap();
        drive(2'b11, 0, 1, 0); cycle();
        for (int c = 1; c < 10; c++) begin
            drive(2'b11, 2*c, 2*c+1, 2);
            #1;
            checks++; if (rd_valid !== 2'b11) begin failures++; $display("[TB] FAIL wrap_valid c=%0d got=%b exp=11", c, rd_valid); end
            checks++; if (rd_data !== {mk(2*c-1), mk(2*c-2)}) begin failures++; $display("[TB] FAIL wrap_data c=%0d got=%h exp=%h", c, rd_data, {mk(2*c-1), mk(2*c-2)}); end
            cycle();
            checks++; if (ib_count !== 4'd2) begin failures++; $display("[TB] FAIL wrap_count c=%0d got=%0d exp=2", c, ib_count); end
        end
        drive(2'b00, 0, 0, 2);
        #1;
        checks++; if (rd_data !== {mk(19), mk(18)}) begin failures++; $display("[TB] FAIL wrap_tail got=%h exp=%h", rd_data, {mk(19), mk(18)}); end
        cycle();
        drive(2'b00, 0, 0, 0);
        checks++; if (ib_count !== 4'd0) begin failures++; $display("[TB] FAIL wrap_drain got=%0d exp=0", ib_count); end
        checks++; if (ib_underflow !== 1'b0) begin failures++; $display("[TB] FAIL wrap_udf got=%b exp=0", ib_underflow); end
    endtask

    task automatic test_bypass();
        drive(2'b11, 'hA0, 'hB0, 1);
        #1;
`ifdef DEC_IB_BYPASS_EN
        checks++; if (rd_valid !== 2'b11) begin failures++; $display("[TB] FAIL byp_valid got=%b exp=11", rd_valid); end
        checks++; if (rd_data !== {mk('hB0), mk('hA0)}) begin failures++; $display("[TB] FAIL byp_data got=%h exp=%h", rd_data, {mk('hB0), mk('hA0)}); end
`else
        checks++; if (rd_valid !== 2'b00) begin failures++; $display("[TB] FAIL nobyp_valid got=%b exp=00", rd_valid); end
        checks++; if (rd_data !== '0) begin failures++; $display("[TB] FAIL nobyp_data got=%h exp=0", rd_data); end
`endif
        cycle();
        drive(2'b00, 0, 0, 0);
        #1;
`ifdef DEC_IB_BYPASS_EN
        checks++; if (ib_count !== 4'd1) begin failures++; $display("[TB] FAIL byp_count got=%0d exp=1", ib_count); end
        checks++; if (rd_valid !== 2'b01) begin failures++; $display("[TB] FAIL byp_next_valid got=%b exp=01", rd_valid); end
        checks++; if (rd_data !== {{PW{1'b0}}, mk('hB0)}) begin failures++; $display("[TB] FAIL byp_next_data got=%h exp=%h", rd_data, {{PW{1'b0}}, mk('hB0)}); end
        checks++; if (ib_underflow !== 1'b0) begin failures++; $display("[TB] FAIL byp_udf got=%b exp=0", ib_underflow); end
`else
        checks++; if (ib_count !== 4'd2) begin failures++; $display("[TB] FAIL nobyp_count got=%0d exp=2", ib_count); end
        checks++; if (rd_valid !== 2'b11) begin failures++; $display("[TB] FAIL nobyp_next_valid got=%b exp=11", rd_valid); end
        checks++; if (rd_data !== {mk('hB0), mk('hA0)}) begin failures++; $display("[TB] FAIL nobyp_next_data got=%h exp=%h", rd_data, {mk('hB0), mk('hA0)}); end
        checks++; if (ib_underflow !== 1'b1) begin failures++; $display("[TB] FAIL nobyp_udf got=%b exp=1", ib_underflow); end
`endif
        do_flush();
    endtask

    task automatic test_flush_collision();
        // Raise underflow first so the flush has a flag to clear.
        drive(2'b00, 0, 0, 1); cycle();
        drive(2'b11, 'h30, 'h31, 0); cycle();
        drive(2'b01, 'h32, 0, 0); cycle();
        drive(2'b00, 0, 0, 0);
        checks++; if (ib_count !== 4'd3) begin failures++; $display("[TB] FAIL flush_pre_count got=%0d exp=3", ib_count); end
        checks++; if (ib_underflow !== 1'b1) begin failures++; $display("[TB] FAIL flush_pre_udf got=%b exp=1", ib_underflow); end
        drive(2'b11, 'h40, 'h41, 2);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        drive(2'b00, 0, 0, 0);
        #1;
        checks++; if (ib_count !== 4'd0) begin failures++; $display("[TB] FAIL flush_count got=%0d exp=0", ib_count); end
        checks++; if (rd_valid !== 2'b00) begin failures++; $display("[TB] FAIL flush_rd_valid got=%b exp=00", rd_valid); end
        checks++; if ({ib_overflow, ib_underflow} !== 2'b00) begin failures++; $display("[TB] FAIL flush_flags got=%b exp=00", {ib_overflow, ib_underflow}); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("[TB] FAIL flush_ready got=%b exp=1", wr_ready); end
    endtask

    task automatic test_underflow();
        drive(2'b01, 'h50, 0, 0); cycle();
        drive(2'b00, 0, 0, 2); cycle();
        drive(2'b00, 0, 0, 0);
        checks++; if (ib_count !== 4'd0) begin failures++; $display("[TB] FAIL udf_count got=%0d exp=0", ib_count); end
        checks++; if (ib_underflow !== 1'b1) begin failures++; $display("[TB] FAIL udf_set got=%b exp=1", ib_underflow); end
        cycle();
        checks++; if (ib_underflow !== 1'b1) begin failures++; $display("[TB] FAIL udf_sticky got=%b exp=1", ib_underflow); end
        do_flush();
        checks++; if (ib_underflow !== 1'b0) begin failures++; $display("[TB] FAIL udf_clear got=%b exp=0", ib_underflow); end
    endtask

    initial begin
        test_reset();
        test_fill_full();
        test_wrap();
        test_bypass();
        test_flush_collision();
        test_underflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
